wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order writeback stage
//  and a long-latency result source (MDU / late load return).
//  Late results are queued in a small FIFO. Each cycle the arbiter grants the port
//  to one source and stalls the pipeline when the FIFO must drain.
//  Sits between the WB stage result mux and the register file.
// PARAMETERS
//  XLEN        32  data width
//  DEPTH       4   late-result FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   max consecutive pipe grants while FIFO non-empty before a forced drain
// PORTS
//  clk_i               in   1         clock, rising edge
//  rst_i               in   1         asynchronous reset, active-high
//  pipe_valid_i        in   1         WB stage holds a valid instruction
//  pipe_we_i           in   1         that instruction writes rd
//  pipe_rd_i           in   5         WB destination register
//  pipe_data_i         in   XLEN      WB result (output of WB select mux)
//  pipe_stall_o        out  1         hold WB stage this cycle (combinational)
//  pipe_rd_pending_o   out  1         a queued late entry targets pipe_rd_i (combinational)
//  late_valid_i        in   1         late result offered
//  late_rd_i           in   5         late destination register
//  late_data_i         in   XLEN      late result data
//  late_ready_o        out  1         FIFO can accept (= !full)
//  rf_we_o             out  1         register-file write enable (registered)
//  rf_rd_o             out  5         register-file write address (registered)
//  rf_wdata_o          out  XLEN      register-file write data (registered)
//  count_o             out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  - Reset (async, rst_i=1):
//    - FIFO emptied; starve counter = 0.
//    - rf_we_o/rf_rd_o/rf_wdata_o = 0; count_o = 0.
//    - late_ready_o = 1; pipe_stall_o = 0 whenever pipe_req = 0.
//    - Reset mid-operation discards all queued entries; no write is issued for them.
//  - pipe_req = pipe_valid_i & pipe_we_i & (pipe_rd_i != 0).
//    - pipe_valid_i with rd = 0 or we = 0 never requests and never stalls.
//  - Push: late_valid_i & late_ready_o.
//    - Entries with late_rd_i = 0 are accepted but not stored.
//    - late_ready_o depends only on full, never on the same-cycle pop.
//  - Grant, one source per cycle. force_drain = (count_o == DEPTH) | (starve == STARVE_MAX).
//    - Buffer wins if FIFO non-empty & (force_drain | !pipe_req).
//    - Otherwise pipe wins if pipe_req.
//    - Otherwise idle.
//  - pipe_stall_o = pipe_req & buffer wins. While stalled, WB holds its inputs stable.
//  - Starve counter:
//    - +1 (saturating) each cycle the pipe wins while FIFO non-empty.
//    - Cleared when the buffer wins or the FIFO is empty.
//  - Write port: the winner's rd/data is registered. rf_we_o = 1 in the cycle after
//    the grant (1-cycle latency). Idle cycle -> rf_we_o = 0 next cycle; rd/data hold.
//  - Pop of the FIFO head happens on a buffer grant.
//    - Simultaneous push and pop when not full: count unchanged, order preserved.
//  - FIFO order is strict FIFO; pointers wrap modulo DEPTH.
//  - pipe_rd_pending_o: compares pipe_rd_i against all valid FIFO entries
//    (rd = 0 never matches). The hazard unit uses it to hold dependent instructions.
// TESTING
//  - Reset: assert rst_i mid-stream with 3 entries queued -> count_o=0, rf_we_o=0,
//    late_ready_o=1 in the same cycle; no queued write appears after release.
//  - Pipe only: pipe_req with rd=5, data=0xDEADBEEF -> next cycle rf_we_o=1,
//    rf_rd_o=5, rf_wdata_o=0xDEADBEEF, pipe_stall_o=0.
//  - Late when pipe idle: push rd=7, data=0x12 -> 1 cycle later buffer granted,
//    2 cycles later rf_we_o=1, rf_rd_o=7, count_o back to 0.
//  - Starvation: 1 entry queued, pipe_req every cycle -> pipe wins 8 cycles, then
//    pipe_stall_o=1 for one cycle and the late entry is written; pipe resumes.
//  - Full: fill 4 entries with pipe busy -> late_ready_o=0, buffer wins immediately,
//    push refused until count_o=3; rd=0 pushes never raise count_o.
//  - Hazard flag: queue rd=9, present pipe_rd_i=9 -> pipe_rd_pending_o=1;
//    with pipe_rd_i=0 -> 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order WB stage vs. a FIFO of late results.
// The FIFO drains when the pipe is idle, when it is full, or after STARVE_MAX pipe wins.
module wb_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pipe_valid_i,
  input  logic                         pipe_we_i,
  input  logic [4:0]                   pipe_rd_i,
  input  logic [XLEN-1:0]              pipe_data_i,
  output logic                         pipe_stall_o,
  output logic                         pipe_rd_pending_o,
  input  logic                         late_valid_i,
  input  logic [4:0]                   late_rd_i,
  input  logic [XLEN-1:0]              late_data_i,
  output logic                         late_ready_o,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_rd_o,
  output logic [XLEN-1:0]              rf_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [StW-1:0]  StOne   = StW'(1);
  localparam logic [StW-1:0]  StMax   = StW'(STARVE_MAX);

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic pipe_req, full, empty, push, force_drain, buf_win, pipe_win;

  always_comb begin
    pipe_req    = pipe_valid_i & pipe_we_i & (pipe_rd_i != 5'd0);
    full        = (count_q == CntFull);
    empty       = (count_q == '0);
    push        = late_valid_i & ~full & (late_rd_i != 5'd0);
    force_drain = full | (starve_q == StMax);
    buf_win     = ~empty & (force_drain | ~pipe_req);
    pipe_win    = pipe_req & ~buf_win;

    late_ready_o = ~full;
    pipe_stall_o = pipe_req & buf_win;

    pipe_rd_pending_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_mem_q[i] == pipe_rd_i) && (pipe_rd_i != 5'd0)) begin
        pipe_rd_pending_o = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = buf_win ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    unique case ({push, buf_win})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    if (buf_win || empty) begin
      starve_d = '0;
    end else if (pipe_win && (starve_q != StMax)) begin
      starve_d = starve_q + StOne;
    end

    if (buf_win) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = rd_mem_q[rd_ptr_q];
      rf_wdata_d = data_mem_q[rd_ptr_q];
    end else if (pipe_win) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = pipe_rd_i;
      rf_wdata_d = pipe_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      vld_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= 5'd0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      // Push and pop never share a slot: push needs !full, pop needs !empty.
      if (push) begin
        rd_mem_q[wr_ptr_q]   <= late_rd_i;
        data_mem_q[wr_ptr_q] <= late_data_i;
        vld_q[wr_ptr_q]      <= 1'b1;
      end
      if (buf_win) begin
        vld_q[rd_ptr_q] <= 1'b0;
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_wdata_o = rf_wdata_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_wb_port_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pipe_valid = 1'b0, pipe_we = 1'b0;
  logic [4:0]      pipe_rd = '0;
  logic [XLEN-1:0] pipe_data = '0;
  logic            pipe_stall, pipe_rd_pending;
  logic            late_valid = 1'b0;
  logic [4:0]      late_rd = '0;
  logic [XLEN-1:0] late_data = '0;
  logic            late_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [2:0]      count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  int              m_starve = 0;
  logic            m_we = 1'b0;
  logic [4:0]      m_rd = '0;
  logic [XLEN-1:0] m_data = '0;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_valid_i(pipe_valid), .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd),
    .pipe_data_i(pipe_data), .pipe_stall_o(pipe_stall), .pipe_rd_pending_o(pipe_rd_pending),
    .late_valid_i(late_valid), .late_rd_i(late_rd), .late_data_i(late_data),
    .late_ready_o(late_ready), .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata),
    .count_o(count)
  );

  always #5 clk = ~clk;

  function automatic bit m_req();
    return pipe_valid && pipe_we && (pipe_rd != 0);
  endfunction

  function automatic bit m_buf_wins();
    int n = mq.size();
    return (n > 0) && ((n == DEPTH) || (m_starve == STARVE_MAX) || !m_req());
  endfunction

  // Advance the reference model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    bit bw = m_buf_wins();
    bit pw = m_req() && !bw;
    int n  = mq.size();
    if (bw) begin
      m_we = 1'b1; m_rd = mq[0].rd; m_data = mq[0].data;
    end else if (pw) begin
      m_we = 1'b1; m_rd = pipe_rd; m_data = pipe_data;
    end else begin
      m_we = 1'b0;
    end
    if (bw || n == 0) m_starve = 0;
    else if (pw && m_starve < STARVE_MAX) m_starve++;
    if (bw) mq.delete(0);
    if (late_valid && n < DEPTH && late_rd != 0) begin
      ent_t e;
      e.rd = late_rd; e.data = late_data;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete(); m_starve = 0; m_we = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic idle_inputs();
    pipe_valid = 0; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    late_valid = 0; late_rd = 0; late_data = 0;
  endtask

  task automatic set_pipe(input logic [4:0] rd, input logic [XLEN-1:0] data);
    pipe_valid = 1; pipe_we = 1; pipe_rd = rd; pipe_data = data;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (rf_we !== 0) begin errors++; $display("FAIL rst_we got %0b exp 0", rf_we); end
    checks++; if (late_ready !== 1) begin errors++; $display("FAIL rst_ready got %0b exp 1", late_ready); end
    checks++; if (pipe_stall !== 0) begin errors++; $display("FAIL rst_stall got %0b exp 0", pipe_stall); end
    @(posedge clk); #1; rst = 0; model_clear();
    // Queue three entries behind a busy pipe, then reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      set_pipe(5'd3, 32'h100 + i);
      late_valid = 1; late_rd = 5'(i + 1); late_data = 32'hA0 + i;
      tick();
    end
    idle_inputs();
    checks++; if (count !== 3) begin errors++; $display("FAIL pre_rst_count got %0d exp 3", count); end
    rst = 1; #1;
    checks++; if (count !== 0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", count); end
    checks++; if (rf_we !== 0) begin errors++; $display("FAIL mid_rst_we got %0b exp 0", rf_we); end
    checks++; if (late_ready !== 1) begin errors++; $display("FAIL mid_rst_ready got %0b exp 1", late_ready); end
    @(posedge clk); #1; rst = 0; model_clear();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rf_we !== 0) begin errors++; $display("FAIL post_rst_we got %0b exp 0", rf_we); end
    end
  endtask

  task automatic test_pipe_only();
    set_pipe(5'd5, 32'hDEADBEEF); #1;
    checks++; if (pipe_stall !== 0) begin errors++; $display("FAIL pipe_stall got %0b exp 0", pipe_stall); end
    tick();
    idle_inputs();
    checks++; if (rf_we !== 1) begin errors++; $display("FAIL pipe_we got %0b exp 1", rf_we); end
    checks++; if (rf_rd !== 5) begin errors++; $display("FAIL pipe_rd got %0d exp 5", rf_rd); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_data got %0h exp deadbeef", rf_wdata); end
    // rd=0 and we=0 never request.
    pipe_valid = 1; pipe_we = 1; pipe_rd = 0; pipe_data = 32'h55;
    tick();
    checks++; if (rf_we !== 0) begin errors++; $display("FAIL rd0_we got %0b exp 0", rf_we); end
    checks++; if (rf_rd !== 5) begin errors++; $display("FAIL hold_rd got %0d exp 5", rf_rd); end
    pipe_we = 0; pipe_rd = 4;
    tick();
    idle_inputs();
    checks++; if (rf_we !== 0) begin errors++; $display("FAIL we0_we got %0b exp 0", rf_we); end
  endtask

  task automatic test_late_idle();
    late_valid = 1; late_rd = 7; late_data = 32'h12;
    tick();
    idle_inputs();
    checks++; if (count !== 1) begin errors++; $display("FAIL late_count1 got %0d exp 1", count); end
    tick();
    checks++; if (rf_we !== 1 || rf_rd !== 7 || rf_wdata !== 32'h12) begin
      errors++; $display("FAIL late_write got we=%0b rd=%0d data=%0h exp 1/7/12", rf_we, rf_rd, rf_wdata);
    end
    checks++; if (count !== 0) begin errors++; $display("FAIL late_count0 got %0d exp 0", count); end
  endtask

  task automatic test_starvation();
    set_pipe(5'd3, 32'h0);
    late_valid = 1; late_rd = 11; late_data = 32'hCAFE;
    tick();
    late_valid = 0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      pipe_data = 32'(i + 1); #1;
      checks++; if (pipe_stall !== 0) begin errors++; $display("FAIL starve_stall%0d got %0b exp 0", i, pipe_stall); end
      tick();
      checks++; if (rf_rd !== 3 || rf_wdata !== 32'(i + 1)) begin
        errors++; $display("FAIL starve_pipe%0d got rd=%0d data=%0h exp 3/%0h", i, rf_rd, rf_wdata, i + 1);
      end
    end
    checks++; if (pipe_stall !== 1) begin errors++; $display("FAIL starve_force got %0b exp 1", pipe_stall); end
    tick();
    checks++; if (rf_rd !== 11 || rf_wdata !== 32'hCAFE) begin
      errors++; $display("FAIL starve_drain got rd=%0d data=%0h exp 11/cafe", rf_rd, rf_wdata);
    end
    checks++; if (pipe_stall !== 0) begin errors++; $display("FAIL starve_resume got %0b exp 0", pipe_stall); end
    tick();
    idle_inputs();
    checks++; if (rf_rd !== 3 || rf_wdata !== 32'(STARVE_MAX)) begin
      errors++; $display("FAIL starve_after got rd=%0d data=%0h exp 3/%0h", rf_rd, rf_wdata, STARVE_MAX);
    end
  endtask

  task automatic test_full();
    set_pipe(5'd2, 32'h77);
    for (int i = 0; i < DEPTH; i++) begin
      late_valid = 1; late_rd = 5'(i + 1); late_data = 32'hB0 + i;
      tick();
    end
    late_rd = 5; late_data = 32'hBAD; #1;
    checks++; if (count !== 4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    checks++; if (late_ready !== 0) begin errors++; $display("FAIL full_ready got %0b exp 0", late_ready); end
    checks++; if (pipe_stall !== 1) begin errors++; $display("FAIL full_stall got %0b exp 1", pipe_stall); end
    tick();
    checks++; if (count !== 3) begin errors++; $display("FAIL full_refuse got %0d exp 3", count); end
    checks++; if (rf_rd !== 1) begin errors++; $display("FAIL full_head got %0d exp 1", rf_rd); end
    checks++; if (late_ready !== 1) begin errors++; $display("FAIL full_ready3 got %0b exp 1", late_ready); end
    late_rd = 0; late_data = 32'h0;
    tick();
    checks++; if (count !== 3) begin errors++; $display("FAIL rd0_push got %0d exp 3", count); end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_rd !== 5'(i + 2) || rf_wdata !== 32'hB0 + i + 1) begin
        errors++; $display("FAIL full_order%0d got rd=%0d data=%0h exp %0d", i, rf_rd, rf_wdata, i + 2);
      end
    end
    checks++; if (count !== 0) begin errors++; $display("FAIL full_empty got %0d exp 0", count); end
  endtask

  task automatic test_hazard();
    set_pipe(5'd3, 32'h1);
    late_valid = 1; late_rd = 9; late_data = 32'h99;
    tick();
    late_valid = 0;
    pipe_rd = 9; #1;
    checks++; if (pipe_rd_pending !== 1) begin errors++; $display("FAIL haz_match got %0b exp 1", pipe_rd_pending); end
    pipe_rd = 0; #1;
    checks++; if (pipe_rd_pending !== 0) begin errors++; $display("FAIL haz_rd0 got %0b exp 0", pipe_rd_pending); end
    pipe_rd = 10; #1;
    checks++; if (pipe_rd_pending !== 0) begin errors++; $display("FAIL haz_other got %0b exp 0", pipe_rd_pending); end
    idle_inputs();
    tick();
    checks++; if (count !== 0) begin errors++; $display("FAIL haz_drain got %0d exp 0", count); end
  endtask

  task automatic test_random();
    bit hold = 0;
    for (int c = 0; c < 400; c++) begin
      bit exp_pend = 0;
      if (!hold) begin
        pipe_valid = 1'($urandom_range(0, 3) != 0);
        pipe_we    = 1'($urandom_range(0, 5) != 0);
        pipe_rd    = 5'($urandom_range(0, 7));
        pipe_data  = $urandom;
      end
      late_valid = 1'($urandom_range(0, 1));
      late_rd    = 5'($urandom_range(0, 7));
      late_data  = $urandom;
      #1;
      foreach (mq[i]) if (mq[i].rd == pipe_rd && pipe_rd != 0) exp_pend = 1;
      checks++; if (pipe_stall !== (m_req() && m_buf_wins())) begin
        errors++; $display("FAIL rnd_stall c=%0d got %0b exp %0b", c, pipe_stall, m_req() && m_buf_wins());
      end
      checks++; if (late_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, late_ready, mq.size() < DEPTH);
      end
      checks++; if (pipe_rd_pending !== exp_pend) begin
        errors++; $display("FAIL rnd_pend c=%0d got %0b exp %0b", c, pipe_rd_pending, exp_pend);
      end
      hold = m_req() && m_buf_wins();
      tick();
      checks++; if (rf_we !== m_we || rf_rd !== m_rd || rf_wdata !== m_data) begin
        errors++; $display("FAIL rnd_rf c=%0d got %0b/%0d/%0h exp %0b/%0d/%0h",
                           c, rf_we, rf_rd, rf_wdata, m_we, m_rd, m_data);
      end
      checks++; if (count !== 3'(mq.size())) begin
        errors++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count, mq.size());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_late_idle();
    test_starvation();
    test_full();
    test_hazard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
